// File: rtl/cabin_mode_arbiter.sv
// Cabin lighting mode arbiter: synchronises and debounces crew/emergency inputs, then
// arbitrates them into a registered 2-bit mode. Define CABIN_DIM_TIMEOUT_EN for DIMMING auto-return.
module cabin_mode_arbiter #(
    parameter int DEB_CYCLES  = 4,
    parameter int DIM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_normal,
    input  logic       btn_dim,
    input  logic       btn_off,
    input  logic       emergency_req,
    input  logic       emergency_clr,
    output logic [1:0] mode_select,
    output logic       mode_change,
    output logic       emerg_active,
    output logic [7:0] change_count
);

    localparam int NIN     = 5;
    localparam int I_NORM  = 0;
    localparam int I_DIM   = 1;
    localparam int I_OFF   = 2;
    localparam int I_EMERG = 3;
    localparam int I_CLR   = 4;

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        NORMAL    = 2'b01,
        DIMMING   = 2'b10,
        EMERGENCY = 2'b11
    } mode_t;

    mode_t            state;
    mode_t            state_nxt;
    logic [NIN-1:0]   raw;
    logic [NIN-1:0]   sync_p0;
    logic [NIN-1:0]   sync_p1;
    logic [NIN-1:0]   level_p2;
    logic [NIN-1:0]   level_q_p3;
    logic [NIN-1:0]   press;
    logic [CNT_W-1:0] deb_cnt [NIN];

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign raw = {emergency_clr, emergency_req, btn_off, btn_dim, btn_normal};

    // Stage p0/p1: two-flop synchroniser
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2/p3: debounce filter and one-cycle delayed level for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_p2   <= '0;
            level_q_p3 <= '0;
            for (int i = 0; i < NIN; i++) deb_cnt[i] <= '0;
        end else begin
            level_q_p3 <= level_p2;
            for (int i = 0; i < NIN; i++) begin
                if (sync_p1[i] == level_p2[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    level_p2[i] <= sync_p1[i];
                    deb_cnt[i]  <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    assign press = level_p2 & ~level_q_p3;

`ifdef CABIN_DIM_TIMEOUT_EN
    localparam int TO_W = (DIM_TIMEOUT > 1) ? $clog2(DIM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] DIM_LAST = TO_W'(DIM_TIMEOUT - 1);
    localparam logic [TO_W-1:0] DIM_ONE  = TO_W'(1);

    logic [TO_W-1:0] dim_cnt;
    logic            dim_expired;

    assign dim_expired = (dim_cnt == DIM_LAST);

    // Counter sits at zero outside DIMMING, so entry always starts a fresh interval
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dim_cnt <= '0;
        end else if (state == DIMMING) begin
            dim_cnt <= dim_cnt + DIM_ONE;
        end else begin
            dim_cnt <= '0;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        if (state != EMERGENCY && press[I_EMERG]) begin
            state_nxt = EMERGENCY;
        end else begin
            case (state)
                IDLE: begin
                    if (press[I_NORM]) state_nxt = NORMAL;
                end
                NORMAL: begin
                    if (press[I_OFF])      state_nxt = IDLE;
                    else if (press[I_DIM]) state_nxt = DIMMING;
                end
                DIMMING: begin
                    if (press[I_OFF])       state_nxt = IDLE;
                    else if (press[I_NORM]) state_nxt = NORMAL;
`ifdef CABIN_DIM_TIMEOUT_EN
                    else if (dim_expired)   state_nxt = NORMAL;
`endif
                end
                EMERGENCY: begin
                    // Clear is honoured only once the debounced request has dropped
                    if (press[I_CLR] && !level_p2[I_EMERG]) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Stage out: mode register and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            mode_change  <= 1'b0;
            emerg_active <= 1'b0;
            change_count <= 8'd0;
        end else begin
            state        <= state_nxt;
            mode_change  <= (state_nxt != state);
            emerg_active <= (state_nxt == EMERGENCY);
            if (state_nxt != state) change_count <= sat_inc(change_count);
        end
    end

    assign mode_select = state;

endmodule
